// File: rtl/segway_pkg.sv
// Shared definitions for the load-cell / battery conditioning slice.
//   ADC_W            width of every A2D reading
//   BATT_THRESH_DEF  default battery-low threshold
//   DIFF_SAT_POS/NEG saturation codes for the signed 12-bit load difference
//   ld_state_t       averaging FSM states
//   sat_diff         saturated signed difference of two unsigned readings
//   sat_add          unsigned add clamped at all-ones
package segway_pkg;

    localparam int ADC_W = 12;

    localparam logic [ADC_W-1:0] BATT_THRESH_DEF = 12'h800;
    localparam logic [ADC_W-1:0] DIFF_SAT_POS    = 12'h7FF;
    localparam logic [ADC_W-1:0] DIFF_SAT_NEG    = 12'h800;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } ld_state_t;

    // 13-bit signed a-b lies in -4095..4095; clamp it into 12-bit two's complement.
    // The top two bits of d disagree exactly when the value is outside -2048..2047.
    function automatic logic [ADC_W-1:0] sat_diff(input logic [ADC_W-1:0] a,
                                                   input logic [ADC_W-1:0] b);
        logic [ADC_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (!d[ADC_W] && d[ADC_W-1]) begin
            sat_diff = DIFF_SAT_POS;
        end else if (d[ADC_W] && !d[ADC_W-1]) begin
            sat_diff = DIFF_SAT_NEG;
        end else begin
            sat_diff = d[ADC_W-1:0];
        end
    endfunction

    function automatic logic [ADC_W-1:0] sat_add(input logic [ADC_W-1:0] a,
                                                  input logic [ADC_W-1:0] b);
        logic [ADC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ADC_W]) begin
            sat_add = {ADC_W{1'b1}};
        end else begin
            sat_add = s[ADC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/boxcar_avg.sv
// Boxcar accumulator for one load-cell channel.
//   clk, rst   clock, asynchronous active-high reset
//   smpl_vld   din holds a new reading this clock
//   dump       this sample is the last of the window (only meaningful with smpl_vld)
//   clr        discard the partial window (watchdog timeout); avg holds
//   din        12-bit unsigned reading
//   avg        registered window average, updated when a window completes
//   avg_nxt    average the window would produce if this sample completes it;
//              lets the parent register a value derived from the new average
//              on the same edge that updates avg
module boxcar_avg
    import segway_pkg::*;
#(
    parameter int unsigned AVG_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smpl_vld,
    input  logic             dump,
    input  logic             clr,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] avg,
    output logic [ADC_W-1:0] avg_nxt
);

    localparam int unsigned ACC_W = ADC_W + AVG_SHIFT;

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_s;
    logic [ADC_W-1:0] avg_r;

    // Running sum including the sample presented this clock; 2^AVG_SHIFT
    // full-scale readings fit exactly in ACC_W bits.
    always_comb begin
        sum_s = acc_r + {{AVG_SHIFT{1'b0}}, din};
    end

    assign avg_nxt = sum_s[ACC_W-1:AVG_SHIFT];
    assign avg     = avg_r;

    // Accumulator: restart empty after a completed or discarded window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (smpl_vld && dump) begin
            acc_r <= '0;
        end else if (smpl_vld) begin
            acc_r <= sum_s;
        end
    end

    // Average register: loads the truncated mean when a window completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_r <= '0;
        end else if (smpl_vld && dump) begin
            avg_r <= avg_nxt;
        end
    end

endmodule

// File: rtl/ld_cell_cond.sv
// Load-cell / battery conditioning between the A2D interface and the
// balance controller / piezo driver.
//   clk, rst       clock, asynchronous active-high reset
//   smpl_vld       1-clk pulse: lft_ld/rght_ld/batt hold a new A2D round
//   lft_ld/rght_ld 12-bit unsigned load cell readings
//   batt           12-bit unsigned battery reading
//   lft_avg/rght_avg  boxcar averages over 2^AVG_SHIFT samples
//   ld_cell_diff   saturated signed lft_avg - rght_avg
//   diff_vld       1-clk pulse, one clock after the sample completing a window
//   batt_low       battery low with hysteresis
//   stale          no smpl_vld for TMO_CYC clocks
module ld_cell_cond
    import segway_pkg::*;
#(
    parameter int unsigned      AVG_SHIFT   = 2,
    parameter logic [ADC_W-1:0] BATT_THRESH = BATT_THRESH_DEF,
    parameter logic [ADC_W-1:0] BATT_HYST   = 12'h040,
    parameter logic [19:0]      TMO_CYC     = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smpl_vld,
    input  logic [ADC_W-1:0] lft_ld,
    input  logic [ADC_W-1:0] rght_ld,
    input  logic [ADC_W-1:0] batt,
    output logic [ADC_W-1:0] lft_avg,
    output logic [ADC_W-1:0] rght_avg,
    output logic [ADC_W-1:0] ld_cell_diff,
    output logic             diff_vld,
    output logic             batt_low,
    output logic             stale
);

    localparam logic [AVG_SHIFT-1:0] CNT_LAST = {AVG_SHIFT{1'b1}};
    localparam logic [AVG_SHIFT-1:0] CNT_ONE  = AVG_SHIFT'(1);
    localparam logic [ADC_W-1:0]     BATT_CLR = sat_add(BATT_THRESH, BATT_HYST);

    ld_state_t            state_r;
    ld_state_t            state_nxt_s;
    logic [AVG_SHIFT-1:0] cnt_r;
    logic [19:0]          wd_cnt_r;
    logic [19:0]          wd_nxt_s;
    logic                 stale_r;
    logic                 stale_nxt_s;
    logic                 enter_stale_s;
    logic                 complete_s;
    logic [ADC_W-1:0]     lft_nxt_s;
    logic [ADC_W-1:0]     rght_nxt_s;
    logic [ADC_W-1:0]     diff_r;
    logic                 batt_low_r;

    // Next-state logic: watchdog count, stale entry, window completion.
    // DUMP is the single clock in which diff_vld is high; a sample arriving
    // then is accumulated normally and so seeds the next window.
    always_comb begin
        wd_nxt_s      = wd_cnt_r;
        stale_nxt_s   = 1'b0;
        enter_stale_s = 1'b0;
        complete_s    = 1'b0;
        state_nxt_s   = state_r;

        if (smpl_vld) begin
            wd_nxt_s = 20'd0;
        end else if (wd_cnt_r != TMO_CYC) begin
            wd_nxt_s = wd_cnt_r + 20'd1;
        end else begin
            wd_nxt_s = wd_cnt_r;
        end
        stale_nxt_s   = (wd_nxt_s == TMO_CYC);
        enter_stale_s = stale_nxt_s && !stale_r;

        case (state_r)
            ACCUM: begin
                if (smpl_vld && (cnt_r == CNT_LAST)) begin
                    complete_s  = 1'b1;
                    state_nxt_s = DUMP;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DUMP: begin
                state_nxt_s = ACCUM;
            end
            default: begin
                state_nxt_s = ACCUM;
            end
        endcase

        if (enter_stale_s) begin
            complete_s  = 1'b0;
            state_nxt_s = ACCUM;
        end else begin
            complete_s = complete_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample counter; wraps to zero as the last sample of a window is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (enter_stale_s) begin
            cnt_r <= '0;
        end else if (smpl_vld) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    boxcar_avg #(.AVG_SHIFT(AVG_SHIFT)) u_lft_avg (
        .clk      (clk),
        .rst      (rst),
        .smpl_vld (smpl_vld),
        .dump     (complete_s),
        .clr      (enter_stale_s),
        .din      (lft_ld),
        .avg      (lft_avg),
        .avg_nxt  (lft_nxt_s)
    );

    boxcar_avg #(.AVG_SHIFT(AVG_SHIFT)) u_rght_avg (
        .clk      (clk),
        .rst      (rst),
        .smpl_vld (smpl_vld),
        .dump     (complete_s),
        .clr      (enter_stale_s),
        .din      (rght_ld),
        .avg      (rght_avg),
        .avg_nxt  (rght_nxt_s)
    );

    // Difference register: built from the averages being loaded this edge,
    // zeroed when the data goes stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r <= '0;
        end else if (enter_stale_s) begin
            diff_r <= '0;
        end else if (complete_s) begin
            diff_r <= sat_diff(lft_nxt_s, rght_nxt_s);
        end
    end

    // Battery-low hysteresis, evaluated only on fresh samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batt_low_r <= 1'b0;
        end else if (smpl_vld) begin
            if (batt < BATT_THRESH) begin
                batt_low_r <= 1'b1;
            end else if (batt >= BATT_CLR) begin
                batt_low_r <= 1'b0;
            end
        end
    end

    // Watchdog counter and stale flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_r <= 20'd0;
            stale_r  <= 1'b0;
        end else begin
            wd_cnt_r <= wd_nxt_s;
            stale_r  <= stale_nxt_s;
        end
    end

    assign ld_cell_diff = diff_r;
    assign diff_vld     = (state_r == DUMP);
    assign batt_low     = batt_low_r;
    assign stale        = stale_r;

endmodule
